// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, context-save targets,
// interrupt-save FSM states and the write-entry record.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] PC_REG_DEF   = 5'd30;
    localparam logic [REG_ADDR_W-1:0] RAND_REG_DEF = 5'd31;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SAVE_PC   = 2'd1,
        SAVE_RAND = 2'd2,
        ACK       = 2'd3
    } irq_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_entry_t;

    // x0 is hard-wired to zero, so a write there is consumed but never issued.
    function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus bundle between the write sources, the arbiter and the register file port.
interface reg_write_arbiter_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  PIPE_WE;
    logic [REG_ADDR_W-1:0] PIPE_ADDR;
    logic [DATA_W-1:0]     PIPE_DATA;

    logic                  IRQ;
    logic [DATA_W-1:0]     IRQ_PC;
    logic [DATA_W-1:0]     RAND_IN;
    logic                  IRQ_ACK;

    logic                  NOC_VALID;
    logic [REG_ADDR_W-1:0] NOC_ADDR;
    logic [DATA_W-1:0]     NOC_DATA;
    logic                  NOC_READY;

    logic                  WB_EN;
    logic [REG_ADDR_W-1:0] WB_ADDR;
    logic [DATA_W-1:0]     WB_DATA;
    logic [CNT_W-1:0]      FIFO_COUNT;

    modport master (
        output PIPE_WE, PIPE_ADDR, PIPE_DATA,
        output IRQ, IRQ_PC, RAND_IN,
        output NOC_VALID, NOC_ADDR, NOC_DATA,
        input  IRQ_ACK, NOC_READY, WB_EN, WB_ADDR, WB_DATA, FIFO_COUNT
    );

    modport slave (
        input  PIPE_WE, PIPE_ADDR, PIPE_DATA,
        input  IRQ, IRQ_PC, RAND_IN,
        input  NOC_VALID, NOC_ADDR, NOC_DATA,
        output IRQ_ACK, NOC_READY, WB_EN, WB_ADDR, WB_DATA, FIFO_COUNT
    );

endinterface

// File: rtl/reg_write_arbiter_wr_fifo.sv
// Small synchronous FIFO of {addr,data} register writes; the head is readable
// combinationally so the arbiter can grant and pop it in the same cycle.
module wr_fifo
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  wr_entry_t        push_entry,
    input  logic             pop,
    output wr_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;
    wr_entry_t        slot_rd [DEPTH];

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slot_rd[rd_ptr_q];
    assign count   = count_q;

    // Storage slots carry no reset: only occupied slots are ever read.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        wr_entry_t slot_q, slot_d;

        always_comb begin
            slot_d = slot_q;
            if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                slot_d = push_entry;
            end
        end

        always_ff @(posedge CLK) begin
            slot_q <= slot_d;
        end

        assign slot_rd[gi] = slot_q;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Merges pipeline writeback, interrupt context save and queued NoC loads onto
// the single register-file write port with fixed priority and registered outputs.
module reg_write_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [REG_ADDR_W-1:0] PC_REG     = PC_REG_DEF,
    parameter logic [REG_ADDR_W-1:0] RAND_REG   = RAND_REG_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    reg_write_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    irq_state_t            state_q, state_d;
    logic [DATA_W-1:0]     pc_cap_q, pc_cap_d;
    logic [DATA_W-1:0]     rand_cap_q, rand_cap_d;
    logic                  irq_ack_q, irq_ack_d;
    logic                  wb_en_q, wb_en_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;

    logic                  grant;
    wr_entry_t             grant_entry;
    wr_entry_t             noc_entry;
    wr_entry_t             fifo_head;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    assign noc_entry.addr = bus.NOC_ADDR;
    assign noc_entry.data = bus.NOC_DATA;

    wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .CLK        (CLK),
        .RESET      (RESET),
        .push       (bus.NOC_VALID),
        .push_entry (noc_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        pc_cap_d    = pc_cap_q;
        rand_cap_d  = rand_cap_q;
        irq_ack_d   = 1'b0;
        grant       = 1'b0;
        grant_entry = '0;
        fifo_pop    = 1'b0;

        // Pipeline can never stall, so it pre-empts the save sequence and the FIFO.
        if (bus.PIPE_WE) begin
            grant            = 1'b1;
            grant_entry.addr = bus.PIPE_ADDR;
            grant_entry.data = bus.PIPE_DATA;
        end else if (state_q == SAVE_PC) begin
            grant            = 1'b1;
            grant_entry.addr = PC_REG;
            grant_entry.data = pc_cap_q;
            state_d          = SAVE_RAND;
        end else if (state_q == SAVE_RAND) begin
            grant            = 1'b1;
            grant_entry.addr = RAND_REG;
            grant_entry.data = rand_cap_q;
            state_d          = ACK;
            irq_ack_d        = 1'b1;
        end else if (!fifo_empty) begin
            grant       = 1'b1;
            grant_entry = fifo_head;
            fifo_pop    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.IRQ) begin
                    state_d    = SAVE_PC;
                    pc_cap_d   = bus.IRQ_PC;
                    rand_cap_d = bus.RAND_IN;
                end
            end
            ACK:     state_d = IDLE;
            default: ;
        endcase

        wb_en_d   = grant && writes_reg(grant_entry.addr);
        wb_addr_d = wb_en_d ? grant_entry.addr : '0;
        wb_data_d = wb_en_d ? grant_entry.data : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            pc_cap_q   <= '0;
            rand_cap_q <= '0;
            irq_ack_q  <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_cap_q   <= pc_cap_d;
            rand_cap_q <= rand_cap_d;
            irq_ack_q  <= irq_ack_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign bus.WB_EN      = wb_en_q;
    assign bus.WB_ADDR    = wb_addr_q;
    assign bus.WB_DATA    = wb_data_q;
    assign bus.IRQ_ACK    = irq_ack_q;
    assign bus.NOC_READY  = !fifo_full;
    assign bus.FIFO_COUNT = fifo_count;

endmodule
